// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl -- multi-cycle multiply/divide sequencer owning HI/LO for EX.
//
// The result is computed combinationally when the op is accepted and parked
// in an internal register; the FSM only counts the op's latency before
// committing it to HI/LO, so Busy timing matches a real iterative unit.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-low; clears HI/LO, FSM, counter, Done
//   Start    MD instruction valid this cycle (ignored while Busy)
//   MDOp     0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6..7 no-op
//   A, B     rs / rt operands
//   HiLoSel  1 selects HI onto MDOut, 0 selects LO
//   Abort    (MD_ABORT_EN only) drop the in-flight op without committing
//   Busy     mult/div in flight
//   Done     one-cycle pulse in the cycle after HI/LO commit
//   MDOut    HiLoSel ? HI : LO, combinational from the registers
//
// Build option: define MD_ABORT_EN to add the Abort input.

module md_unit_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,   // 1..15
    parameter int unsigned DIV_CYCLES  = 10   // 1..15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        HiLoSel,
`ifdef MD_ABORT_EN
    input  logic        Abort,
`endif
    output logic        Busy,
    output logic        Done,
    output logic [31:0] MDOut
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      state, state_d;
    logic [3:0]  cnt, cnt_d;
    logic [31:0] hi, lo;
    logic [63:0] res_q;       // pending {HI,LO} of the in-flight op
    logic        dz_q;        // in-flight op was a divide by zero: no commit
    logic        done_d;
    logic        ld, commit, wr_hi, wr_lo;
    logic        abort_in;

`ifdef MD_ABORT_EN
    assign abort_in = Abort;
`else
    assign abort_in = 1'b0;
`endif

    // ---------------- result datapath ----------------
    logic [63:0]        prod_s, prod_u;
    logic               div_ovf;
    logic [31:0]        dvsr_u;
    logic signed [31:0] dvsr_s, quo_s, rem_s;
    logic [31:0]        quo_u, rem_u;
    logic [63:0]        res_d;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    // The one signed overflow case and divide-by-zero are steered onto a safe
    // divisor; their results are either overridden or never committed.
    assign div_ovf = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
    assign dvsr_u  = (B == 32'd0) ? 32'd1 : B;
    assign dvsr_s  = (B == 32'd0 || div_ovf) ? 32'sd1 : $signed(B);
    assign quo_s   = div_ovf ? 32'sh8000_0000 : $signed(A) / dvsr_s;
    assign rem_s   = div_ovf ? 32'sd0         : $signed(A) % dvsr_s;
    assign quo_u   = A / dvsr_u;
    assign rem_u   = A % dvsr_u;

    always_comb begin
        case (MDOp)
            3'd0:    res_d = prod_s;
            3'd1:    res_d = prod_u;
            3'd2:    res_d = {rem_s, quo_s};
            default: res_d = {rem_u, quo_u};
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
            Done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            Done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        done_d  = 1'b0;
        ld      = 1'b0;
        commit  = 1'b0;
        wr_hi   = 1'b0;
        wr_lo   = 1'b0;
        case (state)
            IDLE: begin
                if (Start && !abort_in) begin
                    case (MDOp)
                        3'd0, 3'd1: begin
                            ld      = 1'b1;
                            state_d = MUL;
                            cnt_d   = 4'(MULT_CYCLES - 1);
                        end
                        3'd2, 3'd3: begin
                            ld      = 1'b1;
                            state_d = DIV;
                            cnt_d   = 4'(DIV_CYCLES - 1);
                        end
                        3'd4:    wr_hi = 1'b1;
                        3'd5:    wr_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                if (abort_in) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt == 4'd0) begin
                    commit  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // ---------------- HI/LO and pending result ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi    <= 32'd0;
            lo    <= 32'd0;
            res_q <= 64'd0;
            dz_q  <= 1'b0;
        end else begin
            if (ld) begin
                res_q <= res_d;
                dz_q  <= MDOp[1] && (B == 32'd0);
            end
            if (commit && !dz_q) begin
                hi <= res_q[63:32];
                lo <= res_q[31:0];
            end
            if (wr_hi) hi <= A;
            if (wr_lo) lo <= A;
        end
    end

    assign Busy  = (state != IDLE);
    assign MDOut = HiLoSel ? hi : lo;

endmodule

// File: tb/tb_md_unit_ctrl.sv
module tb_md_unit_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A, B;
    logic        HiLoSel;
    logic        Busy, Done;
    logic [31:0] MDOut;
`ifdef MD_ABORT_EN
    logic        Abort = 1'b0;
`endif

    md_unit_ctrl dut (
        .clk(clk), .reset(reset), .Start(Start), .MDOp(MDOp), .A(A), .B(B),
        .HiLoSel(HiLoSel),
`ifdef MD_ABORT_EN
        .Abort(Abort),
`endif
        .Busy(Busy), .Done(Done), .MDOut(MDOut)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;
    logic [31:0] hi_m, lo_m;   // reference HI/LO

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result of an op, straight from the arithmetic definitions.
    function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op >= 3'd2 && b == 32'd0) return {h, l};
        case (op)
            3'd0: return 64'(sa * sb);
            3'd1: return ua * ub;
            3'd2: begin
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            default: return {32'(ua % ub), 32'(ua / ub)};
        endcase
    endfunction

    task automatic read_hilo(output logic [31:0] h, output logic [31:0] l);
        HiLoSel = 1'b1; #1; h = MDOut;
        HiLoSel = 1'b0; #1; l = MDOut;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Issue one op and check it cycle by cycle. Entered and left at posedge+1.
    // spur: 0 quiet, 1 random Starts while busy, 2 mtlo A=5 while busy.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int spur);
        logic [63:0] exp;
        logic [31:0] h, l;
        int n;
        exp = ref_res(op, a, b, hi_m, lo_m);
        Start = 1'b1; MDOp = op; A = a; B = b;
        tick();
        Start = 1'b0;
        if (op <= 3'd3) begin
            n = (op <= 3'd1) ? 5 : 10;
            for (int k = 1; k <= n; k++) begin
                read_hilo(h, l);
                chk("busy_hi", Busy, 1'b1);
                chk("busy_done", Done, 1'b0);
                chk("busy_hival", h, hi_m);
                chk("busy_loval", l, lo_m);
                if (spur == 1) begin
                    Start = 1'($urandom_range(0, 1));
                    MDOp = 3'($urandom_range(0, 7));
                    A = $urandom; B = $urandom;
                end else if (spur == 2) begin
                    Start = 1'b1; MDOp = 3'd5; A = 32'd5;
                end
                tick();
                Start = 1'b0;
            end
            hi_m = exp[63:32];
            lo_m = exp[31:0];
            read_hilo(h, l);
            chk("end_busy", Busy, 1'b0);
            chk("end_done", Done, 1'b1);
            chk("end_hi", h, hi_m);
            chk("end_lo", l, lo_m);
            tick();
            chk("done_once", Done, 1'b0);
        end else begin
            if (op == 3'd4) hi_m = a;
            if (op == 3'd5) lo_m = a;
            read_hilo(h, l);
            chk("mt_busy", Busy, 1'b0);
            chk("mt_done", Done, 1'b0);
            chk("mt_hi", h, hi_m);
            chk("mt_lo", l, lo_m);
        end
    endtask

    initial begin
        logic [31:0] h, l, ra, rb;
        logic [2:0]  rop;
        reset = 1'b0; Start = 1'b0; MDOp = 3'd0; A = 32'd0; B = 32'd0; HiLoSel = 1'b0;
        hi_m = 32'd0; lo_m = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        read_hilo(h, l);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_hi", h, 32'd0);
        chk("rst_lo", l, 32'd0);
        reset = 1'b1;
        tick();

        // Directed cases with literal expectations.
        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, 0);
        read_hilo(h, l);
        chk("mult_hi", h, 32'hFFFF_FFFF);
        chk("mult_lo", l, 32'hFFFF_FFFA);
        run_op(3'd1, 32'hFFFF_FFFF, 32'd2, 0);
        read_hilo(h, l);
        chk("multu_hi", h, 32'h0000_0001);
        chk("multu_lo", l, 32'hFFFF_FFFE);
        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        read_hilo(h, l);
        chk("div_hi", h, 32'hFFFF_FFFF);
        chk("div_lo", l, 32'hFFFF_FFFD);
        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        read_hilo(h, l);
        chk("divovf_hi", h, 32'd0);
        chk("divovf_lo", l, 32'h8000_0000);
        run_op(3'd4, 32'h11, 32'd0, 0);
        run_op(3'd5, 32'h22, 32'd0, 0);
        run_op(3'd3, 32'h1234, 32'd0, 0);
        read_hilo(h, l);
        chk("dz_hi", h, 32'h11);
        chk("dz_lo", l, 32'h22);
        run_op(3'd3, 32'd100, 32'd7, 2);   // mtlo while busy must be dropped
        read_hilo(h, l);
        chk("mtlo_busy_lo", l, 32'd14);
        run_op(3'd4, 32'hABCD, 32'd0, 0);
        HiLoSel = 1'b1; #1;
        chk("mthi_mdout", MDOut, 32'hABCD);
        run_op(3'd6, 32'hDEAD, 32'd1, 0);
        run_op(3'd7, 32'hBEEF, 32'd1, 0);

        // Reset in the middle of a divide.
        Start = 1'b1; MDOp = 3'd2; A = 32'd99; B = 32'd4;
        tick();
        Start = 1'b0;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        read_hilo(h, l);
        chk("arst_busy", Busy, 1'b0);
        chk("arst_hi", h, 32'd0);
        chk("arst_lo", l, 32'd0);
        hi_m = 32'd0; lo_m = 32'd0;
        #1 reset = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("arst_nodone", Done, 1'b0);
            chk("arst_idle", Busy, 1'b0);
        end

`ifdef MD_ABORT_EN
        run_op(3'd4, 32'h55, 32'd0, 0);
        Start = 1'b1; MDOp = 3'd0; A = 32'd9; B = 32'd9;
        tick();
        Start = 1'b0;
        tick();
        tick();
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        read_hilo(h, l);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_done", Done, 1'b0);
        chk("abort_hi", h, hi_m);
        chk("abort_lo", l, lo_m);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_nodone", Done, 1'b0);
        end
        Start = 1'b1; MDOp = 3'd4; A = 32'h77; Abort = 1'b1;
        tick();
        Start = 1'b0; Abort = 1'b0;
        HiLoSel = 1'b1; #1;
        chk("abort_start_drop", MDOut, hi_m);
        tick();
`endif

        // Randomized ops against the reference model.
        for (int i = 0; i < 150; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            run_op(rop, ra, rb, 1);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
